// File: rtl/audio_pkg.sv
// Shared definitions for the WM8750 audio path (ADC receiver and DAC serializer).
package audio_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SYNC  = 2'd1,
        RX_LEFT  = 2'd2,
        RX_RIGHT = 2'd3
    } rx_state_t;

    localparam logic LRC_LEFT  = 1'b0;
    localparam logic LRC_RIGHT = 1'b1;

    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int DEF_SLOT_BITS    = 32;

    // PicoRV32 GPIO word indices used by the top-level decode.
    localparam int GPIO_WORD_SAMPLES = 4;
    localparam int GPIO_WORD_STATUS  = 13;

    function automatic logic [31:0] status_word(input logic rdy, input logic ovfl,
                                                input logic err);
        return {29'd0, err, ovfl, rdy};
    endfunction

endpackage

// File: rtl/audio_sync_edge.sv
// N-stage synchronizer for an asynchronous input, with a one-cycle rising-edge strobe.
module audio_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/audio_adc_rx.sv
// I2S capture for the WM8750 ADC: oversamples bclk/lrc/dat, deserializes left/right
// words and exposes them with sticky ready/overflow/short-slot flags for the CPU.
module audio_adc_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int SLOT_BITS    = DEF_SLOT_BITS,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    audio_bclk,
    input  logic                    audio_adclrc,
    input  logic                    audio_adcdat,
    input  logic                    read_ack,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    output logic                    data_rdy,
    output logic                    data_ovfl,
    output logic                    frame_err
);

    localparam int                CNT_W  = $clog2(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_SW  = CNT_W'(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_BITS);

    logic bclk_lvl_unused, bclk_rise;
    logic lrc_s, lrc_rise_unused;
    logic dat_s, dat_rise_unused;

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk_i(clk), .rst_i(reset), .d_i(audio_bclk), .q_o(bclk_lvl_unused), .rise_o(bclk_rise)
    );
    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrc (
        .clk_i(clk), .rst_i(reset), .d_i(audio_adclrc), .q_o(lrc_s), .rise_o(lrc_rise_unused)
    );
    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dat (
        .clk_i(clk), .rst_i(reset), .d_i(audio_adcdat), .q_o(dat_s), .rise_o(dat_rise_unused)
    );

    rx_state_t               state_q, state_d;
    logic                    lrc_prev_q, lrc_prev_d;
    logic                    prev_vld_q, prev_vld_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
    logic [SAMPLE_WIDTH-1:0] right_hold_q, right_hold_d;
    logic                    left_vld_q, left_vld_d;
    logic                    commit_q, commit_d;
    logic                    lrc_chg, short_close;

    logic [SAMPLE_WIDTH-1:0] left_sample_q, right_sample_q;
    logic                    sample_valid_q, data_rdy_q, data_ovfl_q, frame_err_q;

    always_comb begin
        state_d      = state_q;
        lrc_prev_d   = lrc_prev_q;
        prev_vld_d   = prev_vld_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        left_hold_d  = left_hold_q;
        right_hold_d = right_hold_q;
        left_vld_d   = left_vld_q;
        commit_d     = 1'b0;
        short_close  = 1'b0;
        // prev_vld keeps the first edge after reset from faking a word-select change.
        lrc_chg      = bclk_rise && prev_vld_q && (lrc_s != lrc_prev_q);

        if (bclk_rise) begin
            lrc_prev_d = lrc_s;
            prev_vld_d = 1'b1;
        end

        case (state_q)
            RX_IDLE: begin
                left_vld_d = 1'b0;
                bit_cnt_d  = '0;
                shift_d    = '0;
                if (enable) state_d = RX_SYNC;
            end
            RX_SYNC: begin
                if (lrc_chg) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = (lrc_s == LRC_LEFT) ? RX_LEFT : RX_RIGHT;
                end
            end
            RX_LEFT, RX_RIGHT: begin
                if (lrc_chg) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = (state_q == RX_LEFT) ? RX_RIGHT : RX_LEFT;
                    if (bit_cnt_q < CNT_SW) begin
                        short_close = 1'b1;
                        left_vld_d  = 1'b0;
                    end else if (state_q == RX_LEFT) begin
                        left_hold_d = shift_q;
                        left_vld_d  = 1'b1;
                    end else begin
                        right_hold_d = shift_q;
                        commit_d     = left_vld_q;
                        left_vld_d   = 1'b0;
                    end
                end else if (bclk_rise) begin
                    if (bit_cnt_q < CNT_SW)  shift_d   = {shift_q[SAMPLE_WIDTH-2:0], dat_s};
                    if (bit_cnt_q < CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (!enable) state_d = RX_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RX_IDLE;
            lrc_prev_q   <= 1'b0;
            prev_vld_q   <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            right_hold_q <= '0;
            left_vld_q   <= 1'b0;
            commit_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lrc_prev_q   <= lrc_prev_d;
            prev_vld_q   <= prev_vld_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            left_hold_q  <= left_hold_d;
            right_hold_q <= right_hold_d;
            left_vld_q   <= left_vld_d;
            commit_q     <= commit_d;
        end
    end

    // Frame publish: a completion and a CPU ack in the same cycle leave data_rdy set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_sample_q  <= '0;
            right_sample_q <= '0;
            sample_valid_q <= 1'b0;
            data_rdy_q     <= 1'b0;
            data_ovfl_q    <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sample_valid_q <= commit_q;
            if (commit_q) begin
                left_sample_q  <= left_hold_q;
                right_sample_q <= right_hold_q;
            end

            if (commit_q)      data_rdy_q <= 1'b1;
            else if (read_ack) data_rdy_q <= 1'b0;

            if (commit_q && data_rdy_q && !read_ack) data_ovfl_q <= 1'b1;
            else if (read_ack)                       data_ovfl_q <= 1'b0;

            if (short_close)   frame_err_q <= 1'b1;
            else if (read_ack) frame_err_q <= 1'b0;
        end
    end

    assign left_sample  = left_sample_q;
    assign right_sample = right_sample_q;
    assign sample_valid = sample_valid_q;
    assign data_rdy     = data_rdy_q;
    assign data_ovfl    = data_ovfl_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Scoreboard bench for audio_adc_rx: an I2S BFM drives frames, a monitor checks each sample_valid.
module tb_audio_adc_rx;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset, enable, bclk, lrc, dat, read_ack;
    logic [15:0] left_sample, right_sample;
    logic        sample_valid, data_rdy, data_ovfl, frame_err;

    frame_t exp_q[$];
    int     total = 0;
    int     bad   = 0;

    always #5 clk = ~clk;

    audio_adc_rx dut (
        .clk(clk), .reset(reset), .enable(enable),
        .audio_bclk(bclk), .audio_adclrc(lrc), .audio_adcdat(dat),
        .read_ack(read_ack),
        .left_sample(left_sample), .right_sample(right_sample),
        .sample_valid(sample_valid), .data_rdy(data_rdy),
        .data_ovfl(data_ovfl), .frame_err(frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: every sample_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (sample_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_frame: got %h/%h required no frame",
                         left_sample, right_sample);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                if (left_sample !== e.l || right_sample !== e.r) begin
                    bad++;
                    $display("FAIL frame: got %h/%h required %h/%h",
                             left_sample, right_sample, e.l, e.r);
                end
            end
        end
    end

    // One I2S half-frame; lrc changes one bit before the MSB, bits 1..16 carry the word.
    task automatic send_half(input logic ch, input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bclk = 1'b0;
            lrc  = ch;
            dat  = (i >= 1 && i <= 16) ? w[16-i] : 1'b0;
            #40;
            bclk = 1'b1;
            #40;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_half(1'b0, l, 32);
        send_half(1'b1, r, 32);
    endtask

    task automatic expect_frame(input logic [15:0] l, input logic [15:0] r);
        frame_t f;
        f.l = l;
        f.r = r;
        exp_q.push_back(f);
    endtask

    // The final right slot only closes on the next left-going lrc edge.
    task automatic close_frame();
        send_half(1'b0, 16'h0000, 1);
        repeat (12) @(negedge clk);
    endtask

    task automatic ack();
        @(posedge clk);
        #1 read_ack = 1'b1;
        @(posedge clk);
        #1 read_ack = 1'b0;
    endtask

    task automatic restart();
        enable = 1'b0;
        repeat (3) @(posedge clk);
        enable = 1'b1;
        @(posedge clk);
        #2;
        send_half(1'b1, 16'h0000, 32);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; bclk = 1'b0; lrc = 1'b0; dat = 1'b0; read_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_left", 32'(left_sample), 32'h0);
        check("rst_right", 32'(right_sample), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_rdy", 32'(data_rdy), 32'h0);
        check("rst_ovfl", 32'(data_ovfl), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);

        // Basic capture
        restart();
        expect_frame(16'h8001, 16'h7FFE);
        send_frame(16'h8001, 16'h7FFE);
        close_frame();
        check("cap_rdy", 32'(data_rdy), 32'h1);
        check("cap_ovfl", 32'(data_ovfl), 32'h0);
        check("cap_err", 32'(frame_err), 32'h0);
        ack();
        check("cap_ack_rdy", 32'(data_rdy), 32'h0);

        // Startup alignment: enable in the middle of a right slot
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        send_half(1'b0, 16'hA5A5, 32);
        fork
            send_half(1'b1, 16'h5A5A, 32);
            begin #(80 * 10); enable = 1'b1; end
        join
        expect_frame(16'h1357, 16'hECA8);
        send_frame(16'h1357, 16'hECA8);
        close_frame();
        check("align_rdy", 32'(data_rdy), 32'h1);

        // Overflow: two frames without an ack
        ack();
        restart();
        expect_frame(16'h1111, 16'h2222);
        expect_frame(16'h3333, 16'h4444);
        send_frame(16'h1111, 16'h2222);
        send_frame(16'h3333, 16'h4444);
        close_frame();
        check("ovfl_set", 32'(data_ovfl), 32'h1);
        check("ovfl_rdy", 32'(data_rdy), 32'h1);
        check("ovfl_left", 32'(left_sample), 32'h3333);
        check("ovfl_right", 32'(right_sample), 32'h4444);
        ack();
        check("ovfl_ack_rdy", 32'(data_rdy), 32'h0);
        check("ovfl_ack_ovfl", 32'(data_ovfl), 32'h0);

        // Simultaneous ack: read_ack covers exactly the publish edge of the second frame
        restart();
        expect_frame(16'h5555, 16'h6666);
        expect_frame(16'h7777, 16'h8888);
        send_frame(16'h5555, 16'h6666);
        send_frame(16'h7777, 16'h8888);
        fork
            send_half(1'b0, 16'h0000, 1);
            begin #73; read_ack = 1'b1; #10; read_ack = 1'b0; end
        join
        repeat (12) @(negedge clk);
        check("simul_rdy", 32'(data_rdy), 32'h1);
        check("simul_ovfl", 32'(data_ovfl), 32'h0);
        check("simul_err", 32'(frame_err), 32'h0);

        // Short left slot
        ack();
        restart();
        send_half(1'b0, 16'hAAAA, 10);
        send_half(1'b1, 16'hBBBB, 32);
        expect_frame(16'h1234, 16'h5678);
        send_frame(16'h1234, 16'h5678);
        close_frame();
        check("short_err", 32'(frame_err), 32'h1);
        check("short_rdy", 32'(data_rdy), 32'h1);
        ack();
        check("short_ack_err", 32'(frame_err), 32'h0);

        // Async reset in the middle of a right slot
        expect_frame(16'h5A5A, 16'hC3C3);
        restart();
        send_frame(16'h5A5A, 16'hC3C3);
        send_half(1'b0, 16'hFFFF, 32);
        fork
            send_half(1'b1, 16'hFFFF, 32);
            begin
                #(80 * 8 + 3);
                reset = 1'b1;
                #1;
                check("arst_left", 32'(left_sample), 32'h0);
                check("arst_right", 32'(right_sample), 32'h0);
                check("arst_valid", 32'(sample_valid), 32'h0);
                check("arst_rdy", 32'(data_rdy), 32'h0);
                check("arst_ovfl", 32'(data_ovfl), 32'h0);
                check("arst_err", 32'(frame_err), 32'h0);
                #10 reset = 1'b0;
            end
        join
        expect_frame(16'h0001, 16'h8000);
        send_frame(16'h0001, 16'h8000);
        close_frame();
        check("arst_post_rdy", 32'(data_rdy), 32'h1);

        repeat (20) @(negedge clk);
        check("pending_frames", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
